fetch_ctrl: RTL

Instruction-fetch sequencer that drives the program counter's control strobes and reads instruction words from memory. It is the initiator on the PC interface: it loads the PC value at start, issues `pc_inc` after every fetch and `pc_write` on a branch. It then presents each fetched word to the decoder through a valid/ack handshake. It sits between the PC register, instruction memory and the decode/control unit.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_timeout.sv | 19 +
 rtl/fetch_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and default sizing for the instruction-fetch sequencer.
package fetch_pkg;
   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_t;
   localparam int FETCH_DATA_W = 16;
   localparam int FETCH_TIMEOUT = 15;
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: clear/enable cycle counter that flags expiry after TIMEOUT enabled cycles.
module fetch_timeout #(
   parameter int TIMEOUT = fetch_pkg::FETCH_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   // expiry is flagged during the TIMEOUT-th enabled cycle so the caller acts on that edge
   assign expired = cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving PC strobes, memory reads and the decoder handshake.
// Define FETCH_TIMEOUT_EN to abort stalled reads after TIMEOUT wait cycles and raise mem_err.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int DATA_W = FETCH_DATA_W,
   parameter int TIMEOUT = FETCH_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   input  logic [DATA_W-1:0] pc_value,
   output logic              pc_inc,
   output logic              pc_write,
   output logic [DATA_W-1:0] pc_wdata,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir_data,
   output logic              ir_valid,
   input  logic              ir_ack,
   input  logic              branch_req,
   input  logic [DATA_W-1:0] branch_target,
   output logic              mem_err
);
   fetch_state_t state;
   logic expired;
`ifdef FETCH_TIMEOUT_EN
   fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk(clk),
      .rst(rst),
      .clr(state != FETCH_WAIT),
      .en(state == FETCH_WAIT),
      .expired(expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT != 0;
   assign expired = 1'b0;
`endif
   // next address is tracked here rather than re-read from pc_value, which lags the strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH_IDLE;
         pc_inc <= 1'b0;
         pc_write <= 1'b0;
         pc_wdata <= '0;
         mem_addr <= '0;
         mem_rd <= 1'b0;
         ir_data <= '0;
         ir_valid <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         pc_inc <= 1'b0;
         pc_write <= 1'b0;
         case (state)
            FETCH_IDLE: if (start) begin
               mem_addr <= pc_value;
               mem_rd <= 1'b1;
               mem_err <= 1'b0;
               state <= FETCH_WAIT;
            end
            FETCH_WAIT: if (mem_ready) begin
               ir_data <= mem_rdata;
               ir_valid <= 1'b1;
               mem_rd <= 1'b0;
               pc_inc <= 1'b1;
               state <= FETCH_HOLD;
            end else if (expired) begin
               mem_rd <= 1'b0;
               mem_err <= 1'b1;
               state <= FETCH_IDLE;
            end
            FETCH_HOLD: if (ir_ack) begin
               ir_valid <= 1'b0;
               pc_write <= branch_req;
               if (branch_req) pc_wdata <= branch_target;
               mem_addr <= branch_req ? branch_target : mem_addr + DATA_W'(1);
               mem_rd <= !halt;
               state <= halt ? FETCH_IDLE : FETCH_WAIT;
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end
endmodule
